// File: rtl/edge_pkg.sv
// Shared types and default constants for the adaptive edge threshold block.
// Includes the clamped threshold step used by the frame update.
package edge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int THR_INIT_D = 18;
    localparam int THR_MIN_D  = 4;
    localparam int THR_MAX_D  = 250;
    localparam int THR_STEP_D = 2;
    localparam int BLANK_D    = 5;

    // 9-bit arithmetic keeps thr+step and thr-step from wrapping.
    function automatic logic [7:0] thr_step(
        input logic [7:0] thr,
        input logic       up,
        input logic [8:0] step,
        input logic [8:0] lo,
        input logic [8:0] hi
    );
        logic [8:0] w_val;
        if (up) begin
            w_val = {1'b0, thr} + step;
            if (w_val > hi)
                w_val = hi;
        end else begin
            if ({1'b0, thr} < lo + step)
                w_val = lo;
            else
                w_val = {1'b0, thr} - step;
        end
        return w_val[7:0];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up counter that sticks at all-ones; clear wins over increment.
// Holds completely while en is low.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (en) begin
            if (clr)
                r_cnt <= '0;
            else if (inc && (r_cnt != '1))
                r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/edge_threshold_ctrl.sv
// Per-frame edge counter that adapts the edge comparator threshold
// toward a target edge-count window, with manual override.
module edge_threshold_ctrl
    import edge_pkg::*;
#(
    parameter int THR_INIT = THR_INIT_D,
    parameter int THR_MIN  = THR_MIN_D,
    parameter int THR_MAX  = THR_MAX_D,
    parameter int THR_STEP = THR_STEP_D,
    parameter int BLANK    = BLANK_D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enb,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic        pix_valid,
    input  logic [7:0]  deriv,
    input  logic        manual_en,
    input  logic [7:0]  manual_thr,
    input  logic [15:0] target_lo,
    input  logic [15:0] target_hi,
    output logic [7:0]  thr,
    output logic        cmp_enb,
    output logic [15:0] edge_count,
    output logic        thr_valid
);

    localparam logic [7:0] BLANK_C = 8'(BLANK);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_thr;
    logic [15:0] r_edge_count;
    logic [7:0]  w_pix_cnt;
    logic [15:0] w_edge_cnt;
    logic [7:0]  w_thr_new;
    logic        w_in_run;
    logic        w_clr;
    logic        w_past_blank;
    logic        w_pix_inc;
    logic        w_edge_inc;

    assign w_in_run     = (r_state == RUN);
    // frame_start in IDLE opens a frame; in RUN it aborts and restarts it.
    assign w_clr        = enb && frame_start && (r_state != UPDATE);
    assign w_past_blank = (w_pix_cnt >= BLANK_C);
    assign w_pix_inc    = enb && w_in_run && pix_valid && !frame_start;
    assign w_edge_inc   = w_pix_inc && w_past_blank && (deriv > r_thr);

    sat_counter #(.W(8)) u_pix_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (enb),
        .clr   (w_clr),
        .inc   (w_pix_inc),
        .cnt   (w_pix_cnt)
    );

    sat_counter #(.W(16)) u_edge_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (enb),
        .clr   (w_clr),
        .inc   (w_edge_inc),
        .cnt   (w_edge_cnt)
    );

    always_comb begin
        w_next = r_state;
        if (enb) begin
            unique case (r_state)
                IDLE:    if (frame_start) w_next = RUN;
                RUN: begin
                    if (frame_start)
                        w_next = RUN;
                    else if (frame_end)
                        w_next = UPDATE;
                end
                UPDATE:  w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_thr_new = r_thr;
        if (manual_en)
            w_thr_new = manual_thr;
        else if (w_edge_cnt > target_hi)
            w_thr_new = thr_step(r_thr, 1'b1, 9'(THR_STEP),
                                 9'(THR_MIN), 9'(THR_MAX));
        else if (w_edge_cnt < target_lo)
            w_thr_new = thr_step(r_thr, 1'b0, 9'(THR_STEP),
                                 9'(THR_MIN), 9'(THR_MAX));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_thr        <= 8'(THR_INIT);
            r_edge_count <= '0;
        end else if (enb && (r_state == UPDATE)) begin
            r_thr        <= w_thr_new;
            r_edge_count <= w_edge_cnt;
        end
    end

    assign thr        = r_thr;
    assign edge_count = r_edge_count;
    assign cmp_enb    = enb && w_in_run && w_past_blank;
    assign thr_valid  = enb && (r_state == UPDATE);

endmodule

// File: tb/tb_edge_threshold_ctrl.sv
// Directed bench: stimulus pushes hand-computed update results into a
// queue; a monitor pops one entry per thr_valid strobe and checks it.
module tb_edge_threshold_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enb;
    logic        frame_start;
    logic        frame_end;
    logic        pix_valid;
    logic [7:0]  deriv;
    logic        manual_en;
    logic [7:0]  manual_thr;
    logic [15:0] target_lo;
    logic [15:0] target_hi;
    logic [7:0]  thr;
    logic        cmp_enb;
    logic [15:0] edge_count;
    logic        thr_valid;

    typedef struct {
        int ec;
        int thr;
    } exp_t;

    exp_t exp_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   pushes  = 0;
    int   strobes = 0;

    always #5 clk = ~clk;

    edge_threshold_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .enb         (enb),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .pix_valid   (pix_valid),
        .deriv       (deriv),
        .manual_en   (manual_en),
        .manual_thr  (manual_thr),
        .target_lo   (target_lo),
        .target_hi   (target_hi),
        .thr         (thr),
        .cmp_enb     (cmp_enb),
        .edge_count  (edge_count),
        .thr_valid   (thr_valid)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_upd(input int ec, input int t);
        exp_t e;
        e.ec  = ec;
        e.thr = t;
        exp_q.push_back(e);
        pushes++;
    endtask

    // Fresh frame of n pixels; optionally the last pixel rides on frame_end.
    task automatic frame(input int n, input logic [7:0] d,
                         input logic end_with_pix);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            deriv     = d;
            frame_end = end_with_pix && (i == n - 1);
            @(negedge clk);
            chk("cmp_enb", int'(cmp_enb), (i >= 5) ? 1 : 0);
            step();
        end
        pix_valid = 1'b0;
        if (!end_with_pix) begin
            frame_end = 1'b1;
            step();
        end
        frame_end = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic pixels(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            deriv     = d;
            step();
        end
        pix_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (thr_valid) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got 1 want 0");
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    chk("edge_count", int'(edge_count), e.ec);
                    chk("thr", int'(thr), e.thr);
                    chk("strobe_width", int'(thr_valid), 0);
                end
            end
        end
    end

    initial begin : stim
        reset       = 1'b1;
        enb         = 1'b1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pix_valid   = 1'b0;
        deriv       = 8'd0;
        manual_en   = 1'b0;
        manual_thr  = 8'd0;
        target_lo   = 16'd0;
        target_hi   = 16'hFFFF;
        step();
        step();
        @(negedge clk);
        chk("rst_thr", int'(thr), 18);
        chk("rst_edge_count", int'(edge_count), 0);
        chk("rst_thr_valid", int'(thr_valid), 0);
        chk("rst_cmp_enb", int'(cmp_enb), 0);
        reset = 1'b0;
        step();

        // 10 pixels, 5 counted, above target_hi -> step up
        target_hi = 16'd3;
        expect_upd(5, 20);
        frame(10, 8'd30, 1'b0);

        // deriv equal to thr never counts; below target_lo -> step down
        target_hi = 16'hFFFF;
        target_lo = 16'd1;
        expect_upd(0, 18);
        frame(8, 8'd20, 1'b0);
        expect_upd(0, 16);
        frame(8, 8'd18, 1'b0);

        manual_en  = 1'b1;
        manual_thr = 8'd100;
        expect_upd(3, 100);
        frame(8, 8'd200, 1'b0);

        // upper clamp
        manual_thr = 8'd249;
        expect_upd(1, 249);
        frame(6, 8'd255, 1'b0);
        manual_en = 1'b0;
        target_lo = 16'd0;
        target_hi = 16'd0;
        expect_upd(1, 250);
        frame(6, 8'd255, 1'b0);
        expect_upd(1, 250);
        frame(6, 8'd255, 1'b0);

        // lower clamp
        manual_en  = 1'b1;
        manual_thr = 8'd5;
        expect_upd(0, 5);
        frame(6, 8'd0, 1'b0);
        manual_en = 1'b0;
        target_lo = 16'd100;
        target_hi = 16'hFFFF;
        expect_upd(0, 4);
        frame(6, 8'd0, 1'b0);
        expect_upd(0, 4);
        frame(6, 8'd0, 1'b0);

        // pixel coincident with frame_end is counted
        target_lo = 16'd0;
        expect_upd(1, 4);
        frame(6, 8'd50, 1'b1);

        // frame_end in IDLE is ignored
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        step();

        // abort by frame_start mid-RUN
        expect_upd(1, 4);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pixels(7, 8'd30);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pixels(6, 8'd30);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        step();
        step();

        // abort by frame_start coincident with frame_end
        expect_upd(1, 4);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pixels(7, 8'd30);
        frame_start = 1'b1;
        frame_end   = 1'b1;
        step();
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pixels(6, 8'd30);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        step();
        step();

        // enb low freezes counting mid-frame
        expect_upd(3, 4);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pixels(6, 8'd30);
        enb       = 1'b0;
        pix_valid = 1'b1;
        deriv     = 8'd30;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("enb0_cmp_enb", int'(cmp_enb), 0);
            step();
        end
        enb       = 1'b1;
        pix_valid = 1'b0;
        pixels(2, 8'd30);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        step();
        step();

        // reset mid-frame discards it
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pixels(8, 8'd30);
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("midrst_thr", int'(thr), 18);
        chk("midrst_edge_count", int'(edge_count), 0);
        chk("midrst_cmp_enb", int'(cmp_enb), 0);
        reset = 1'b0;
        step();
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        repeat (5) step();

        chk("queue_empty", exp_q.size(), 0);
        chk("strobe_count", strobes, pushes);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
